// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: next-PC source sequencer that also owns EPC/Status/Cause; define IRQ_SYNC_EN to add a 2-flop irq synchroniser.
module pc_redirect_ctrl #(
  parameter int IRQ_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             instr_done_i,
  input  logic             br_taken_i,
  input  logic             jmp_i,
  input  logic             exc_req_i,
  input  logic [4:0]       exc_code_i,
  input  logic             eret_i,
  input  logic [IRQ_W-1:0] irq_i,
  input  logic [31:0]      pc_cur_i,
  input  logic             cp0_we_i,
  input  logic             cp0_sel_i,
  input  logic [31:0]      cp0_wdata_i,
  output logic             pc_write_o,
  output logic [2:0]       pc_source_o,
  output logic [31:0]      epc_o,
  output logic [31:0]      status_o,
  output logic [31:0]      cause_o,
  output logic             busy_o
);
  localparam logic [2:0] SRC_SEQ = 3'b001, SRC_BR = 3'b010, SRC_JMP = 3'b011,
                         SRC_EXC = 3'b100, SRC_INT = 3'b101, SRC_EPC = 3'b110;
  typedef enum logic {RUN, CMD} state_t;
  state_t state_q, state_d;
  logic [2:0]       src_q, src_d, sel;
  logic [31:0]      epc_q, epc_d;
  logic             ie_q, ie_d, exl_q, exl_d;
  logic [IRQ_W-1:0] im_q, im_d, ip;
  logic [4:0]       code_q, code_d;
  logic             take, int_ok, trap;
  logic             unused_wdata;
  assign unused_wdata = ^cp0_wdata_i;
`ifdef IRQ_SYNC_EN
  logic [IRQ_W-1:0] irq_s1_q, irq_s2_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      irq_s1_q <= '0;
      irq_s2_q <= '0;
    end else begin
      irq_s1_q <= irq_i;
      irq_s2_q <= irq_s1_q;
    end
  assign ip = irq_s2_q;
`else
  assign ip = irq_i;
`endif
  assign take   = (state_q == RUN) && instr_done_i;
  assign int_ok = ie_q & ~exl_q & |(ip & im_q);
  // interrupt only wins over a plain sequential retirement; otherwise it stays pending
  assign sel = exc_req_i ? SRC_EXC :
               eret_i    ? SRC_EPC :
               jmp_i     ? SRC_JMP :
               br_taken_i ? SRC_BR :
               int_ok    ? SRC_INT : SRC_SEQ;
  assign trap = take && (sel == SRC_EXC || sel == SRC_INT || sel == SRC_EPC);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= RUN;
      src_q   <= '0;
      epc_q   <= '0;
      ie_q    <= 1'b0;
      exl_q   <= 1'b0;
      im_q    <= '0;
      code_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      epc_q   <= epc_d;
      ie_q    <= ie_d;
      exl_q   <= exl_d;
      im_q    <= im_d;
      code_q  <= code_d;
    end
  always_comb state_d = (state_q == RUN) ? (instr_done_i ? CMD : RUN) : RUN;
  always_comb begin
    src_d  = take ? sel : src_q;
    ie_d   = (cp0_we_i && !cp0_sel_i) ? cp0_wdata_i[0] : ie_q;
    im_d   = (cp0_we_i && !cp0_sel_i) ? cp0_wdata_i[8 +: IRQ_W] : im_q;
    exl_d  = (cp0_we_i && !cp0_sel_i && !trap) ? cp0_wdata_i[1] : exl_q;
    epc_d  = (cp0_we_i && cp0_sel_i && !trap) ? {cp0_wdata_i[31:2], 2'b00} : epc_q;
    code_d = code_q;
    if (take && sel == SRC_EXC) begin
      code_d = exc_code_i;
      epc_d  = exl_q ? epc_q : pc_cur_i;
      exl_d  = 1'b1;
    end
    if (take && sel == SRC_INT) begin
      code_d = 5'd0;
      epc_d  = pc_cur_i + 32'd4;
      exl_d  = 1'b1;
    end
    if (take && sel == SRC_EPC) exl_d = 1'b0;
  end
  always_comb begin
    pc_write_o  = (state_q == CMD);
    busy_o      = (state_q == CMD);
    pc_source_o = (state_q == CMD) ? src_q : 3'b000;
    epc_o       = epc_q;
    status_o    = '0;
    status_o[0] = ie_q;
    status_o[1] = exl_q;
    status_o[8 +: IRQ_W] = im_q;
    cause_o     = '0;
    cause_o[6:2] = code_q;
    cause_o[8 +: IRQ_W] = ip;
  end
endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb_pc_redirect_ctrl: vector table for source selection and CP0 state, plus hand sequences for CMD hold, ERET/CP0 clash, async reset and irq lag.
module tb_pc_redirect_ctrl;
  localparam int W = 6;
  logic clk = 0, reset = 1;
  logic instr_done = 0, br = 0, jmp = 0, exc = 0, eret = 0, we = 0, sel = 0;
  logic [4:0] code = 0;
  logic [W-1:0] irq = 0;
  logic [31:0] pc = 0, wd = 0;
  logic pc_write, busy;
  logic [2:0] src;
  logic [31:0] epc, status, cause;
  int total = 0, bad = 0;
  pc_redirect_ctrl #(.IRQ_W(W)) dut (
    .clk(clk), .reset(reset), .instr_done_i(instr_done), .br_taken_i(br),
    .jmp_i(jmp), .exc_req_i(exc), .exc_code_i(code), .eret_i(eret),
    .irq_i(irq), .pc_cur_i(pc), .cp0_we_i(we), .cp0_sel_i(sel),
    .cp0_wdata_i(wd), .pc_write_o(pc_write), .pc_source_o(src),
    .epc_o(epc), .status_o(status), .cause_o(cause), .busy_o(busy));
  always #5 clk = ~clk;
  typedef struct {
    logic pre_we; logic pre_sel; logic [31:0] pre_wd; logic [W-1:0] irq;
    logic exc; logic [4:0] code; logic eret; logic jmp; logic br; logic [31:0] pc;
    logic [2:0] src; logic [31:0] epc; logic [31:0] st; logic [31:0] ca;
  } vec_t;
  vec_t v [12];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic cp0(input logic s, input logic [31:0] d);
    we = 1; sel = s; wd = d;
    step();
    we = 0;
  endtask
  initial begin
    v[0]  = '{0, 0, 32'h0,   0, 0, 0, 0, 0, 0, 32'h100,      3'b001, 32'h0,        32'h0,   32'h0};
    v[1]  = '{0, 0, 32'h0,   0, 0, 0, 0, 1, 1, 32'h104,      3'b011, 32'h0,        32'h0,   32'h0};
    v[2]  = '{0, 0, 32'h0,   0, 0, 0, 0, 0, 1, 32'h108,      3'b010, 32'h0,        32'h0,   32'h0};
    v[3]  = '{0, 0, 32'h0,   0, 0, 0, 1, 0, 0, 32'h10C,      3'b110, 32'h0,        32'h0,   32'h0};
    v[4]  = '{0, 0, 32'h0,   0, 1, 8, 0, 0, 0, 32'h00400010, 3'b100, 32'h00400010, 32'h2,   32'h20};
    v[5]  = '{0, 0, 32'h0,   0, 1, 3, 0, 0, 0, 32'h500,      3'b100, 32'h00400010, 32'h2,   32'h0C};
    v[6]  = '{1, 0, 32'h101, 1, 0, 0, 0, 0, 0, 32'hFFFFFFFC, 3'b101, 32'h0,        32'h103, 32'h100};
    v[7]  = '{1, 1, 32'h80001003, 1, 0, 0, 1, 0, 0, 32'h0,    3'b110, 32'h80001000, 32'h101, 32'h100};
    v[8]  = '{0, 0, 32'h0,   1, 0, 0, 0, 1, 0, 32'h200,      3'b011, 32'h80001000, 32'h101, 32'h100};
    v[9]  = '{1, 0, 32'h100, 1, 0, 0, 0, 0, 0, 32'h300,      3'b001, 32'h80001000, 32'h100, 32'h100};
    v[10] = '{1, 0, 32'h101, 0, 0, 0, 0, 0, 0, 32'h400,      3'b001, 32'h80001000, 32'h101, 32'h0};
    v[11] = '{0, 0, 32'h0,   1, 1, 4, 0, 0, 0, 32'h600,      3'b100, 32'h600,      32'h103, 32'h110};
    step();
    step();
    chk("rst_pc_write", {31'b0, pc_write}, 0);
    chk("rst_src", {29'b0, src}, 0);
    chk("rst_epc", epc, 0);
    chk("rst_status", status, 0);
    chk("rst_cause", cause, 0);
    reset = 0;
    step();
    chk("idle_busy", {31'b0, busy}, 0);
    for (int i = 0; i < 12; i++) begin
      if (v[i].pre_we) cp0(v[i].pre_sel, v[i].pre_wd);
      irq = v[i].irq;
      repeat (3) step();
      instr_done = 1; exc = v[i].exc; code = v[i].code; eret = v[i].eret;
      jmp = v[i].jmp; br = v[i].br; pc = v[i].pc;
      step();
      {instr_done, exc, eret, jmp, br} = '0;
      chk($sformatf("v%0d_pc_write", i), {31'b0, pc_write}, 1);
      chk($sformatf("v%0d_busy", i), {31'b0, busy}, 1);
      chk($sformatf("v%0d_src", i), {29'b0, src}, {29'b0, v[i].src});
      chk($sformatf("v%0d_epc", i), epc, v[i].epc);
      chk($sformatf("v%0d_status", i), status, v[i].st);
      chk($sformatf("v%0d_cause", i), cause, v[i].ca);
      step();
      chk($sformatf("v%0d_drop", i), {28'b0, pc_write, src}, 0);
    end
    // instr_done held through CMD: the second cycle is ignored
    irq = 0;
    repeat (3) step();
    instr_done = 1; jmp = 1;
    step();
    chk("hold_1", {28'b0, pc_write, src}, 4'b1011);
    step();
    chk("hold_2", {31'b0, pc_write}, 0);
    step();
    chk("hold_3", {31'b0, pc_write}, 1);
    instr_done = 0; jmp = 0;
    step();
    chk("hold_4", {31'b0, pc_write}, 0);
    // ERET alongside a CP0 EPC write: the EPC write is dropped
    cp0(0, 32'h2);
    cp0(1, 32'h80001000);
    instr_done = 1; eret = 1; we = 1; sel = 1; wd = 32'h12345678;
    step();
    {instr_done, eret, we} = '0;
    chk("eret_src", {29'b0, src}, 3'b110);
    chk("eret_epc", epc, 32'h80001000);
    chk("eret_exl", {31'b0, status[1]}, 0);
    // CP0 Status write alongside an exception: IE/IM taken, EXL forced to 1
    step();
    instr_done = 1; exc = 1; code = 5; pc = 32'h700; we = 1; sel = 0; wd = 32'h301;
    step();
    {instr_done, exc, we} = '0;
    chk("exc_cp0_status", status, 32'h303);
    chk("exc_cp0_epc", epc, 32'h700);
    step();
    // reset in the middle of CMD clears everything without a clock edge
    instr_done = 1;
    step();
    instr_done = 0;
    chk("pre_rst_pw", {31'b0, pc_write}, 1);
    #2 reset = 1;
    #1;
    chk("async_pw", {31'b0, pc_write}, 0);
    chk("async_src", {29'b0, src}, 0);
    chk("async_epc", epc, 0);
    chk("async_status", status, 0);
    chk("async_cause", cause, 0);
    step();
    reset = 0;
    step();
    irq = 6'b000001;
`ifdef IRQ_SYNC_EN
    #1;
    chk("lag_0", cause, 0);
    step();
    chk("lag_1", cause, 0);
    step();
    chk("lag_2", cause, 32'h100);
`else
    #1;
    chk("ip_comb", cause, 32'h100);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
